// File: rtl/fir_stream_pkg.sv
// rtl/fir_stream_pkg.sv - shared types and arithmetic helpers for the FIR filter
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Clamp a wide signed value into the range of an out_w-bit signed number.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_stream_if.sv
// rtl/fir_stream_if.sv - sample in/out streams plus coefficient write port
interface fir_stream_if #(
  parameter int DATA_W = 10,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 11,
  parameter int ADDR_W = 4
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [OUT_W-1:0]  m_data;
  logic              coef_we;
  logic [ADDR_W-1:0] coef_addr;
  logic [COEF_W-1:0] coef_wdata;
  logic              coef_ready;

  modport slave (
    input  s_valid, s_data, m_ready, coef_we, coef_addr, coef_wdata,
    output s_ready, m_valid, m_data, coef_ready
  );

  modport master (
    output s_valid, s_data, m_ready, coef_we, coef_addr, coef_wdata,
    input  s_ready, m_valid, m_data, coef_ready
  );
endinterface

// File: rtl/fir_stream_mac.sv
// rtl/fir_stream_mac.sv - shared multiplier/accumulator and round/shift/saturate stage
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int COEF_W = 8,
  parameter int TAPS   = 16,
  parameter int SHIFT  = 5,
  parameter int OUT_W  = 11,
  parameter int ROUND  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [COEF_W-1:0] c,
  output logic signed [OUT_W-1:0]  y
);
  localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [63:0] RND = (ROUND != 0 && SHIFT > 0) ? (64'sd1 <<< RND_SH) : 64'sd0;

  logic signed [DATA_W+COEF_W-1:0] prod;
  logic signed [ACC_W-1:0]         acc;
  logic signed [63:0]              r;

  assign prod = x * c;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

  assign r = 64'(acc) + RND;
  assign y = OUT_W'(sat(r >>> SHIFT, OUT_W));

endmodule

// File: rtl/fir_stream.sv
// rtl/fir_stream.sv - time-multiplexed FIR: FSM, delay line, coefficient bank, handshakes
module fir_stream
  import fir_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int COEF_W = 8,
  parameter int TAPS   = 16,
  parameter int SHIFT  = 5,
  parameter int OUT_W  = 11,
  parameter int ROUND  = 1
) (
  input logic         clk,
  input logic         rst,
  fir_stream_if.slave bus
);
  localparam int AW = $clog2(TAPS);
  localparam int KW = $clog2(TAPS + 1);
  localparam logic [KW-1:0] K_LAST = KW'(TAPS);

  state_t state, state_n;
  logic [KW-1:0]            k;
  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [COEF_W-1:0] c [TAPS];
  logic signed [DATA_W-1:0] x_sel;
  logic signed [COEF_W-1:0] c_sel;
  logic signed [OUT_W-1:0]  y;
  logic signed [OUT_W-1:0]  m_data_q;
  logic s_ready_q, coef_ready_q, m_valid_q;
  logic accept, coef_wr, acc_clr, acc_en, load_out;

  assign accept  = (state == IDLE) && bus.s_valid;
  assign coef_wr = bus.coef_we && coef_ready_q && (32'(bus.coef_addr) < TAPS);

  always_comb begin
    state_n  = state;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    load_out = 1'b0;
    case (state)
      IDLE: if (bus.s_valid) begin
        state_n = MAC;
        acc_clr = 1'b1;
      end
      // One extra MAC cycle after the last product lets the output stage see the final sum.
      MAC: if (k == K_LAST) begin
        state_n  = OUT;
        load_out = 1'b1;
      end else begin
        acc_en = 1'b1;
      end
      OUT: if (bus.m_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      k            <= '0;
      s_ready_q    <= 1'b1;
      coef_ready_q <= 1'b1;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
    end else begin
      state        <= state_n;
      s_ready_q    <= (state_n == IDLE);
      coef_ready_q <= (state_n == IDLE);
      m_valid_q    <= (state_n == OUT);
      if (acc_clr) k <= '0;
      else if (acc_en) k <= k + KW'(1);
      if (load_out) m_data_q <= y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        c[i] <= '0;
      end
    end else begin
      if (accept) begin
        x[0] <= bus.s_data;
        for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
      end
      if (coef_wr) c[bus.coef_addr] <= bus.coef_wdata;
    end
  end

  assign x_sel = (k < K_LAST) ? x[k[AW-1:0]] : '0;
  assign c_sel = (k < K_LAST) ? c[k[AW-1:0]] : '0;

  fir_mac #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS),
    .SHIFT(SHIFT), .OUT_W(OUT_W), .ROUND(ROUND)
  ) u_mac (
    .clk(clk), .rst(rst), .clr(acc_clr), .en(acc_en),
    .x(x_sel), .c(c_sel), .y(y)
  );

  assign bus.s_ready    = s_ready_q;
  assign bus.coef_ready = coef_ready_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;

endmodule

// File: tb/tb_fir_stream.sv
// tb/tb_fir_stream.sv - randomized bench for fir_stream against a convolution model
module tb_fir_stream;
  localparam int TAPS = 16;
  localparam int DW = 10;
  localparam int CW = 8;
  localparam int OW = 11;
  localparam int SH = 5;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_stream_if #(.DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .ADDR_W(AW)) bus0 ();
  fir_stream_if #(.DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .ADDR_W(AW)) bus1 ();

  fir_stream #(.DATA_W(DW), .COEF_W(CW), .TAPS(TAPS), .SHIFT(SH), .OUT_W(OW), .ROUND(1))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fir_stream #(.DATA_W(DW), .COEF_W(CW), .TAPS(TAPS), .SHIFT(SH), .OUT_W(OW), .ROUND(0))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus1.s_valid    = bus0.s_valid;
  assign bus1.s_data     = bus0.s_data;
  assign bus1.m_ready    = bus0.m_ready;
  assign bus1.coef_we    = bus0.coef_we;
  assign bus1.coef_addr  = bus0.coef_addr;
  assign bus1.coef_wdata = bus0.coef_wdata;

  int coef [TAPS];
  int hist [TAPS];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint model_out(input int round);
    longint acc;
    longint hi;
    longint lo;
    acc = 0;
    for (int i = 0; i < TAPS; i++) acc += longint'(hist[i]) * longint'(coef[i]);
    if (round != 0) acc += longint'(1) <<< (SH - 1);
    acc = acc >>> SH;
    hi = (longint'(1) <<< (OW - 1)) - 1;
    lo = -(longint'(1) <<< (OW - 1));
    if (acc > hi) acc = hi;
    if (acc < lo) acc = lo;
    return acc;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      coef[i] = 0;
      hist[i] = 0;
    end
  endtask

  task automatic model_push(input int v);
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int a, input int d);
    int n;
    n = 0;
    while (!bus0.coef_ready && n < 100) begin tick(); n++; end
    if (n >= 100) check("coef_ready_timeout", 0, 1);
    bus0.coef_we = 1'b1;
    bus0.coef_addr = AW'(a);
    bus0.coef_wdata = CW'(d);
    tick();
    bus0.coef_we = 1'b0;
    coef[a] = d;
  endtask

  task automatic accept(input int v);
    int n;
    n = 0;
    while (!bus0.s_ready && n < 100) begin tick(); n++; end
    if (n >= 100) check("s_ready_timeout", 0, 1);
    bus0.s_valid = 1'b1;
    bus0.s_data = DW'(v);
    tick();
    bus0.s_valid = 1'b0;
    model_push(v);
  endtask

  task automatic wait_out(input string tag, input int exp_lat, output longint got);
    int n;
    n = 0;
    while (!bus0.m_valid && n < 100) begin tick(); n++; end
    check({tag, "_latency"}, n, exp_lat);
    got = longint'($signed(bus0.m_data));
    check({tag, "_round"}, got, model_out(1));
    check({tag, "_trunc"}, longint'($signed(bus1.m_data)), model_out(0));
  endtask

  task automatic release_out(input string tag);
    bus0.m_ready = 1'b1;
    tick();
    bus0.m_ready = 1'b0;
    check({tag, "_drop"}, longint'(bus0.m_valid), 0);
  endtask

  task automatic send(input string tag, input int v, output longint got);
    accept(v);
    wait_out(tag, TAPS + 1, got);
    release_out(tag);
  endtask

  longint got;
  longint held;

  initial begin
    rst = 1'b1;
    bus0.s_valid = 1'b0;
    bus0.s_data = '0;
    bus0.m_ready = 1'b0;
    bus0.coef_we = 1'b0;
    bus0.coef_addr = '0;
    bus0.coef_wdata = '0;
    model_reset();
    tick();
    tick();
    check("rst_s_ready", longint'(bus0.s_ready), 1);
    check("rst_coef_ready", longint'(bus0.coef_ready), 1);
    check("rst_m_valid", longint'(bus0.m_valid), 0);
    check("rst_m_data", longint'($signed(bus0.m_data)), 0);
    rst = 1'b0;
    tick();

    // impulse response through c[k] = k+1
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    for (int i = 0; i <= TAPS; i++) begin
      send("impulse", (i == 0) ? 32 : 0, got);
      check("impulse_const", got, (i < TAPS) ? i + 1 : 0);
    end

    // saturation both ways
    for (int k = 0; k < TAPS; k++) write_coef(k, 127);
    for (int i = 0; i < TAPS; i++) begin
      send("sat_pos", 511, got);
      if (i == TAPS - 1) check("sat_pos_const", got, 1023);
    end
    for (int i = 0; i < TAPS; i++) begin
      send("sat_neg", -512, got);
      if (i == TAPS - 1) check("sat_neg_const", got, -1024);
    end

    // rounding versus truncation with a single unit tap
    write_coef(0, 1);
    for (int k = 1; k < TAPS; k++) write_coef(k, 0);
    send("round_p16", 16, got);
    check("round_p16_const", got, 1);
    check("trunc_p16_const", longint'($signed(bus1.m_data)), 0);
    send("round_m16", -16, got);
    check("round_m16_const", got, 0);

    // random coefficients and samples with random backpressure
    for (int k = 0; k < TAPS; k++) write_coef(k, int'($urandom_range(0, 255)) - 128);
    for (int i = 0; i < 24; i++) begin
      int hold;
      accept(int'($urandom_range(0, 1023)) - 512);
      wait_out("rand", TAPS + 1, got);
      hold = int'($urandom_range(0, 3));
      for (int h = 0; h < hold; h++) begin
        tick();
        check("rand_hold", longint'($signed(bus0.m_data)), got);
      end
      release_out("rand");
    end

    // backpressure with a pending sample that must wait
    accept(int'($urandom_range(0, 1023)) - 512);
    wait_out("bp", TAPS + 1, held);
    bus0.s_valid = 1'b1;
    bus0.s_data = DW'(77);
    for (int h = 0; h < 5; h++) begin
      tick();
      check("bp_m_valid", longint'(bus0.m_valid), 1);
      check("bp_m_data", longint'($signed(bus0.m_data)), held);
      check("bp_s_ready", longint'(bus0.s_ready), 0);
    end
    release_out("bp");
    accept(77);
    wait_out("bp_next", TAPS + 1, got);
    release_out("bp_next");

    // coefficient write during MAC is dropped
    write_coef(0, 50);
    accept(100);
    tick();
    tick();
    bus0.coef_we = 1'b1;
    bus0.coef_addr = '0;
    bus0.coef_wdata = CW'(-5);
    tick();
    bus0.coef_we = 1'b0;
    bus0.coef_addr = '0;
    wait_out("lock_cur", TAPS - 2, got);
    release_out("lock_cur");
    send("lock_next", 100, got);

    // coefficient write and sample acceptance in the same IDLE cycle
    bus0.coef_we = 1'b1;
    bus0.coef_addr = '0;
    bus0.coef_wdata = CW'(-90);
    bus0.s_valid = 1'b1;
    bus0.s_data = DW'(300);
    tick();
    bus0.coef_we = 1'b0;
    bus0.s_valid = 1'b0;
    coef[0] = -90;
    model_push(300);
    wait_out("same_cyc", TAPS + 1, got);
    release_out("same_cyc");

    // reset in the middle of MAC
    accept(200);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("mid_rst_m_valid", longint'(bus0.m_valid), 0);
    check("mid_rst_s_ready", longint'(bus0.s_ready), 1);
    check("mid_rst_coef_ready", longint'(bus0.coef_ready), 1);
    for (int i = 0; i < 3; i++) begin
      send("post_rst", (i == 0) ? 32 : 0, got);
      check("post_rst_zero", got, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
